// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned IO_PEND_W  = 3;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for the write arbiter: CPU writeback, I/O request handshake, regfile write port.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic                  cpu_writeEnable;
    logic [REG_ADDR_W-1:0] cpu_writeReg;
    logic [REG_DATA_W-1:0] cpu_writeData;
    logic                  io_valid;
    logic [REG_ADDR_W-1:0] io_reg;
    logic [REG_DATA_W-1:0] io_data;
    logic                  io_ready;
    logic                  ctrl_writeEnable;
    logic [REG_ADDR_W-1:0] ctrl_writeReg;
    logic [REG_DATA_W-1:0] data_writeReg;
    logic                  cpu_stall;
    logic [IO_PEND_W-1:0]  io_pending;

    modport master (
        output cpu_writeEnable, cpu_writeReg, cpu_writeData, io_valid, io_reg, io_data,
        input  io_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, cpu_stall, io_pending
    );

    modport slave (
        input  cpu_writeEnable, cpu_writeReg, cpu_writeData, io_valid, io_reg, io_data,
        output io_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, cpu_stall, io_pending
    );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO of write requests; occupancy is its own counter so full/empty need no
// extra pointer bit.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter  int unsigned Depth = 4,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  wr_req_t         wdata_i,
    input  logic            pop_i,
    output wr_req_t         rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    wr_req_t         mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push = push_i && !full_o;
    assign pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges CPU writeback with buffered I/O register writes onto the single regfile write port.
// Optional starvation guard for queued I/O writes: define REGFILE_STARVE_GUARD_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WAIT   = 8
) (
    input logic                     clock,
    input logic                     ctrl_reset,
    regfile_write_arbiter_if.slave  wr_if
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    wr_req_t         push_req, head_req;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CntW-1:0] fifo_count;
    logic            cpu_slot;

    assign push_req = '{addr: wr_if.io_reg, data: wr_if.io_data};

    // r0 requests complete the handshake but are dropped here.
    assign wr_if.io_ready = !fifo_full;
    assign fifo_push      = wr_if.io_valid && !fifo_full && (wr_if.io_reg != REG_ZERO);

    assign cpu_slot = wr_if.cpu_writeEnable && (wr_if.cpu_writeReg != REG_ZERO) &&
                      !wr_if.cpu_stall;
    assign fifo_pop = !fifo_empty && !cpu_slot;

    assign wr_if.io_pending = IO_PEND_W'(fifo_count);

    regfile_wr_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (ctrl_reset),
        .push_i  (fifo_push),
        .wdata_i (push_req),
        .pop_i   (fifo_pop),
        .rdata_o (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        wr_if.ctrl_writeEnable = 1'b0;
        wr_if.ctrl_writeReg    = REG_ZERO;
        wr_if.data_writeReg    = '0;
        if (cpu_slot) begin
            wr_if.ctrl_writeEnable = 1'b1;
            wr_if.ctrl_writeReg    = wr_if.cpu_writeReg;
            wr_if.data_writeReg    = wr_if.cpu_writeData;
        end else if (!fifo_empty) begin
            wr_if.ctrl_writeEnable = 1'b1;
            wr_if.ctrl_writeReg    = head_req.addr;
            wr_if.data_writeReg    = head_req.data;
        end
    end

`ifdef REGFILE_STARVE_GUARD_EN
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    logic [WaitW-1:0] wait_q, wait_d;

    // Head age in cycles; at MAX_WAIT the CPU is held off for one slot.
    assign wr_if.cpu_stall = (wait_q == WaitW'(MAX_WAIT));
    assign wait_d          = (fifo_empty || fifo_pop) ? '0 : wait_q + WaitW'(1);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign wr_if.cpu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, corner sequences and random traffic checked
// against a queue-based model. Honours REGFILE_STARVE_GUARD_EN like the design.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int unsigned Depth   = 4;
    localparam int unsigned MaxWait = 8;
`ifdef REGFILE_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic clock = 1'b0;
    logic ctrl_reset;
    always #5 clock = ~clock;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .FIFO_DEPTH (Depth),
        .MAX_WAIT   (MaxWait)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .wr_if      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending I/O writes in acceptance order, plus cycles the head has waited.
    wr_req_t     q[$];
    int unsigned age;

    typedef struct {
        logic        cpu_we;
        logic [4:0]  cpu_reg;
        logic [31:0] cpu_data;
        logic        io_v;
        logic [4:0]  io_reg;
        logic [31:0] io_data;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic        exp_ready;
        logic [2:0]  exp_pend;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic we, input logic [4:0] creg, input logic [31:0] cdata,
                         input logic iv, input logic [4:0] ireg, input logic [31:0] idata);
        bus.cpu_writeEnable = we;
        bus.cpu_writeReg    = creg;
        bus.cpu_writeData   = cdata;
        bus.io_valid        = iv;
        bus.io_reg          = ireg;
        bus.io_data         = idata;
    endtask

    // Called just after a rising edge with inputs already driven; compares every output with
    // the model at the falling edge, advances the model, returns at the next rising edge + 1.
    task automatic step(output logic o_we, output logic [4:0] o_reg, output logic [31:0] o_data,
                        output logic o_ready, output logic [2:0] o_pend, output logic o_stall);
        bit          ready, stall, cpu_win, drain, accept;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        @(negedge clock);
        ready   = q.size() < Depth;
        stall   = Guard && q.size() != 0 && age >= MaxWait;
        cpu_win = bus.cpu_writeEnable && bus.cpu_writeReg != 5'd0 && !stall;
        drain   = !cpu_win && q.size() != 0;
        if (cpu_win) begin
            e_we = 1'b1; e_reg = bus.cpu_writeReg; e_data = bus.cpu_writeData;
        end else if (drain) begin
            e_we = 1'b1; e_reg = q[0].addr; e_data = q[0].data;
        end else begin
            e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0;
        end
        o_we = bus.ctrl_writeEnable; o_reg = bus.ctrl_writeReg; o_data = bus.data_writeReg;
        o_ready = bus.io_ready; o_pend = bus.io_pending; o_stall = bus.cpu_stall;
        check("model.we", 32'(o_we), 32'(e_we));
        check("model.reg", 32'(o_reg), 32'(e_reg));
        check("model.data", o_data, e_data);
        check("model.io_ready", 32'(o_ready), 32'(ready));
        check("model.io_pending", 32'(o_pend), q.size());
        check("model.cpu_stall", 32'(o_stall), 32'(stall));
        accept = bus.io_valid && ready && bus.io_reg != 5'd0;
        if (drain) begin
            void'(q.pop_front());
            age = 0;
        end else if (q.size() != 0) begin
            age++;
        end else begin
            age = 0;
        end
        if (accept) q.push_back(wr_req_t'{addr: bus.io_reg, data: bus.io_data});
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        age = 0;
    endtask

    initial begin
        vec_t        vecs[9];
        logic        we, rdy, stl;
        logic [4:0]  rg;
        logic [31:0] dt;
        logic [2:0]  pd;
        logic [4:0]  io_seen[$];
        int          stall_cnt, io_hit, stall_hit;

        //        cpu_we reg   data          io   reg   data         we reg   data         rdy pend
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 3'd0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 32'h7,  1'b0, 5'd0,  32'h0,        1'b1, 3'd0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd13, 32'h7,        1'b1, 3'd1};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 3'd0};
        vecs[4] = '{1'b1, 5'd20, 32'h11,       1'b1, 5'd1,  32'h2,  1'b1, 5'd20, 32'h11,       1'b1, 3'd0};
        vecs[5] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,  1'b1, 5'd1,  32'h2,        1'b1, 3'd1};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h99, 1'b0, 5'd0,  32'h0,        1'b1, 3'd0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 3'd0};
        vecs[8] = '{1'b1, 5'd3,  32'hA,        1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  32'hA,        1'b1, 3'd0};

        // Reset state
        ctrl_reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #12 ctrl_reset = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        check("reset.we", 32'(bus.ctrl_writeEnable), 32'd0);
        check("reset.io_ready", 32'(bus.io_ready), 32'd1);
        check("reset.io_pending", 32'(bus.io_pending), 32'd0);
        check("reset.cpu_stall", 32'(bus.cpu_stall), 32'd0);

        // Vector table: CPU path, idle drain, r0 filtering
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].cpu_we, vecs[i].cpu_reg, vecs[i].cpu_data,
                  vecs[i].io_v, vecs[i].io_reg, vecs[i].io_data);
            step(we, rg, dt, rdy, pd, stl);
            check($sformatf("vec%0d.we", i), 32'(we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d.reg", i), 32'(rg), 32'(vecs[i].exp_reg));
            check($sformatf("vec%0d.data", i), dt, vecs[i].exp_data);
            check($sformatf("vec%0d.ready", i), 32'(rdy), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d.pend", i), 32'(pd), 32'(vecs[i].exp_pend));
        end

        // Contention: CPU busy 10 cycles, 4 I/O pushes, then idle drain in order
        for (int i = 0; i < 16; i++) begin
            if (i < 10) drive(1'b1, 5'd7, 32'h1000 + i, i < 4, 5'(10 + i), 32'h200 + i);
            else        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            step(we, rg, dt, rdy, pd, stl);
            if (i == 4) begin
                check("contend.ready_full", 32'(rdy), 32'd0);
                check("contend.pend_full", 32'(pd), 32'd4);
            end
            if (we && rg != 5'd7) io_seen.push_back(rg);
        end
        check("contend.drained", io_seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < io_seen.size()) check($sformatf("contend.order%0d", i),
                                          32'(io_seen[i]), 32'(10 + i));
        end

        // Reset mid-stream with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd7, 32'h3000 + i, 1'b1, 5'(20 + i), 32'h400 + i);
            step(we, rg, dt, rdy, pd, stl);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("midrst.pend_before", 32'(bus.io_pending), 32'd3);
        #2 ctrl_reset = 1'b1;
        #1;
        check("midrst.we", 32'(bus.ctrl_writeEnable), 32'd0);
        check("midrst.reg", 32'(bus.ctrl_writeReg), 32'd0);
        check("midrst.data", bus.data_writeReg, 32'd0);
        check("midrst.pend", 32'(bus.io_pending), 32'd0);
        check("midrst.ready", 32'(bus.io_ready), 32'd1);
        check("midrst.stall", 32'(bus.cpu_stall), 32'd0);
        model_clear();
        @(negedge clock);
        ctrl_reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) step(we, rg, dt, rdy, pd, stl);

        // Starvation: CPU busy throughout, one queued entry
        stall_cnt = 0; io_hit = 0; stall_hit = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd9, 32'hCAFE0000 + i, i == 0, 5'd17, 32'h1234);
            step(we, rg, dt, rdy, pd, stl);
            if (stl) stall_cnt++;
            if (we && rg == 5'd17) begin
                io_hit++;
                if (stl) stall_hit++;
            end
        end
`ifdef REGFILE_STARVE_GUARD_EN
        check("guard.stall_pulses", stall_cnt, 1);
        check("guard.head_written", io_hit, 1);
        check("guard.write_on_stall", stall_hit, 1);
`else
        check("noguard.stall_pulses", stall_cnt, 0);
        check("noguard.head_written", io_hit, 0);
        check("noguard.still_pending", 32'(pd), 32'd1);
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            step(we, rg, dt, rdy, pd, stl);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            step(we, rg, dt, rdy, pd, stl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
